// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: access sizes, arbiter states and
// the latched downstream request record.
package mem_arbiter_pkg;

  localparam int MAX_D_STREAK_DEF = 4;
  localparam int STREAK_W_DEF     = 3;

  typedef enum logic [2:0] {
    MSIZE1 = 3'b000,
    MSIZE2 = 3'b001,
    MSIZE4 = 3'b010,
    MSIZE8 = 3'b011
  } msize_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Grant decision for the memory port: dbus has fixed priority unless ibus has
// been waiting through a full streak of dbus grants.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF,
  parameter int STREAK_W     = STREAK_W_DEF
) (
  input  logic                i_valid,
  input  logic                d_valid,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_i,
  output logic                grant_d
);

  logic streak_full;

  assign streak_full = (streak >= STREAK_W'(MAX_D_STREAK));
  assign grant_d     = d_valid && (!i_valid || !streak_full);
  assign grant_i     = i_valid && !grant_d;

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter between the fetch (ibus) and memory-stage (dbus)
// requesters and the shared memory port.
//
// state  | meaning
// IDLE   | no transaction outstanding; arbitrate and latch the winner
// BUSY_I | ibus request presented downstream, waiting for m_data_ok
// BUSY_D | dbus request presented downstream, waiting for m_data_ok
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF,
  parameter int STREAK_W     = STREAK_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  output logic        i_data_ok,
  output logic [31:0] i_data,
  input  logic        d_valid,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [7:0]  d_strobe,
  input  logic [63:0] d_wdata,
  output logic        d_data_ok,
  output logic [63:0] d_data,
  output logic        m_valid,
  output logic [63:0] m_addr,
  output logic [2:0]  m_size,
  output logic [7:0]  m_strobe,
  output logic [63:0] m_wdata,
  input  logic        m_data_ok,
  input  logic [63:0] m_data,
  output logic        busy,
  output logic        owner
);

  arb_state_t          state_q, state_d;
  mem_req_t            req_q, req_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                grant_i, grant_d;

  arb_pick #(
    .MAX_D_STREAK(MAX_D_STREAK),
    .STREAK_W    (STREAK_W)
  ) u_pick (
    .i_valid(i_valid),
    .d_valid(d_valid),
    .streak (streak_q),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );

  // Next state, request latch contents and streak count.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d      = BUSY_D;
          req_d.valid  = 1'b1;
          req_d.addr   = d_addr;
          req_d.size   = msize_t'(d_size);
          req_d.strobe = d_strobe;
          req_d.wdata  = d_wdata;
          // Only dbus wins taken while ibus is waiting count toward starvation.
          if (!i_valid) begin
            streak_d = '0;
          end else if (streak_q < STREAK_W'(MAX_D_STREAK)) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (grant_i) begin
          state_d      = BUSY_I;
          req_d.valid  = 1'b1;
          req_d.addr   = i_addr;
          req_d.size   = MSIZE4;
          req_d.strobe = '0;
          req_d.wdata  = '0;
          streak_d     = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_data_ok) begin
          state_d     = IDLE;
          req_d.valid = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        req_d.valid = 1'b0;
      end
    endcase
  end

  // State, latch and streak registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      req_q    <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      streak_q <= streak_d;
    end
  end

  assign m_valid  = req_q.valid;
  assign m_addr   = req_q.addr;
  assign m_size   = req_q.size;
  assign m_strobe = req_q.strobe;
  assign m_wdata  = req_q.wdata;

  assign busy  = (state_q != IDLE);
  assign owner = (state_q == BUSY_D);

  // Responses route only to the owner; m_data_ok seen in IDLE goes nowhere.
  assign i_data_ok = m_data_ok && (state_q == BUSY_I);
  assign d_data_ok = m_data_ok && (state_q == BUSY_D);
  assign i_data    = i_data_ok ? (req_q.addr[2] ? m_data[63:32] : m_data[31:0]) : '0;
  assign d_data    = d_data_ok ? m_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level
// reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, d_valid, m_data_ok;
  logic [63:0] i_addr, d_addr, d_wdata, m_data;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic        i_data_ok, d_data_ok, m_valid, busy, owner;
  logic [31:0] i_data;
  logic [63:0] d_data, m_addr, m_wdata;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
    .d_wdata(d_wdata), .d_data_ok(d_data_ok), .d_data(d_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe),
    .m_wdata(m_wdata), .m_data_ok(m_data_ok), .m_data(m_data),
    .busy(busy), .owner(owner)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: at most one pending transaction plus a wait counter.
  bit          mbusy;
  bit          mown;
  logic [63:0] maddr, mwd;
  logic [2:0]  msz;
  logic [7:0]  mstb;
  int          streak;
  bit          glog[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mbusy  = 1'b0;
    streak = 0;
  endfunction

  task automatic model_edge();
    if (mbusy) begin
      if (m_data_ok) mbusy = 1'b0;
    end else if (d_valid && (!i_valid || streak < MAXS)) begin
      mbusy = 1'b1; mown = 1'b1;
      maddr = d_addr; msz = d_size; mstb = d_strobe; mwd = d_wdata;
      glog.push_back(1'b1);
      if (i_valid) streak = (streak < MAXS) ? streak + 1 : streak;
      else         streak = 0;
    end else if (i_valid) begin
      mbusy = 1'b1; mown = 1'b0;
      maddr = i_addr; msz = MSIZE4; mstb = 8'h00; mwd = 64'h0;
      glog.push_back(1'b0);
      streak = 0;
    end
  endtask

  task automatic check_outs();
    logic exp_i, exp_d;
    chk("busy", busy, mbusy);
    chk("m_valid", m_valid, mbusy);
    if (mbusy) begin
      chk("owner", owner, mown);
      chk("m_addr", m_addr, maddr);
      chk("m_size", m_size, msz);
      chk("m_strobe", m_strobe, mstb);
      chk("m_wdata", m_wdata, mwd);
    end
    exp_i = mbusy && !mown && m_data_ok;
    exp_d = mbusy && mown && m_data_ok;
    chk("i_data_ok", i_data_ok, exp_i);
    chk("d_data_ok", d_data_ok, exp_d);
    if (exp_i) chk("i_data", i_data, maddr[2] ? m_data[63:32] : m_data[31:0]);
    if (exp_d) chk("d_data", d_data, m_data);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cyc();
    #1 check_outs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    bit exp_seq[6];
    reset = 1'b0;
    i_valid = 0; d_valid = 0; i_addr = 0; d_addr = 0; d_size = 0;
    d_strobe = 0; d_wdata = 0;
    m_data = 64'hDEAD_BEEF_0123_4567; m_data_ok = 1'b1;
    model_reset();
    #2;
    chk("rst_m_valid", m_valid, 0);   chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);       chk("rst_m_addr", m_addr, 0);
    chk("rst_m_size", m_size, 0);     chk("rst_m_strobe", m_strobe, 0);
    chk("rst_m_wdata", m_wdata, 0);   chk("rst_i_data_ok", i_data_ok, 0);
    chk("rst_d_data_ok", d_data_ok, 0); chk("rst_i_data", i_data, 0);
    chk("rst_d_data", d_data, 0);
    @(negedge clk);
    reset = 1'b1; m_data_ok = 1'b0;

    // Lone fetch, requester withdraws while busy, response two cycles late.
    i_valid = 1; i_addr = 64'h8000_0004;
    cyc();
    i_valid = 0;
    #1 chk("fetch_size", m_size, MSIZE4);
    chk("fetch_strobe", m_strobe, 0);
    chk("fetch_addr", m_addr, 64'h8000_0004);
    cyc(); cyc();
    m_data = 64'h1122_3344_5566_7788; m_data_ok = 1;
    #1 chk("fetch_word", i_data, 32'h1122_3344);
    chk("fetch_ok", i_data_ok, 1);
    chk("fetch_no_d", d_data_ok, 0);
    cyc();
    m_data_ok = 0;
    cyc();

    // Simultaneous requests: dbus first, ibus next.
    glog.delete();
    i_valid = 1; i_addr = 64'h8000_0100;
    d_valid = 1; d_addr = 64'h8000_1000; d_size = MSIZE8; d_strobe = 0; d_wdata = 0;
    cyc();
    d_valid = 0; m_data = 64'h0102_0304_0506_0708; m_data_ok = 1;
    cyc();
    m_data_ok = 0;
    cyc();
    i_valid = 0; m_data = 64'hCAFE_F00D_1234_5678; m_data_ok = 1;
    cyc();
    m_data_ok = 0;
    cyc();
    chk("simul_grants", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("simul_first_d", glog[0], 1);
      chk("simul_then_i", glog[1], 0);
    end

    // Starvation guard.
    glog.delete();
    i_valid = 1; d_valid = 1; m_data_ok = 1; d_addr = 64'h8000_2000;
    repeat (14) cyc();
    i_valid = 0; d_valid = 0;
    repeat (2) cyc();
    m_data_ok = 0;
    cyc();
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    chk("starve_len", glog.size() >= 6, 1);
    if (glog.size() >= 6)
      for (int k = 0; k < 6; k++) chk($sformatf("starve_grant%0d", k), glog[k], exp_seq[k]);

    // Store latched and held while upstream inputs change.
    d_valid = 1; d_addr = 64'h8000_3008; d_size = MSIZE8;
    d_strobe = 8'hF0; d_wdata = 64'hAABB_0000_0000_0000;
    cyc();
    for (int k = 0; k < 3; k++) begin
      d_valid = 1'($urandom_range(0, 1));
      d_addr = {$urandom(), $urandom()};
      d_size = 3'($urandom_range(0, 3));
      d_strobe = 8'($urandom());
      d_wdata = {$urandom(), $urandom()};
      #1 chk("hold_strobe", m_strobe, 8'hF0);
      chk("hold_wdata", m_wdata, 64'hAABB_0000_0000_0000);
      chk("hold_addr", m_addr, 64'h8000_3008);
      cyc();
    end
    d_valid = 0; m_data_ok = 1;
    cyc();
    m_data_ok = 0;
    cyc();

    // Spurious completions while idle.
    m_data_ok = 1;
    repeat (3) cyc();
    m_data_ok = 0;

    // Reset in the middle of a dbus transaction.
    d_valid = 1; d_addr = 64'h8000_4000; d_strobe = 0;
    cyc();
    d_valid = 0;
    cyc();
    reset = 0;
    model_reset();
    #1 chk("midrst_m_valid", m_valid, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1; m_data_ok = 1;
    cyc(); cyc();
    m_data_ok = 0;
    cyc();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      i_valid   = 1'($urandom_range(0, 1));
      i_addr    = {$urandom(), $urandom()} & ~64'h3;
      d_valid   = 1'($urandom_range(0, 1));
      d_addr    = {$urandom(), $urandom()};
      d_size    = 3'($urandom_range(0, 3));
      d_strobe  = ($urandom_range(0, 1) == 1) ? 8'($urandom()) : 8'h00;
      d_wdata   = {$urandom(), $urandom()};
      m_data    = {$urandom(), $urandom()};
      m_data_ok = ($urandom_range(0, 9) < 4);
      cyc();
    end
    i_valid = 0; d_valid = 0; m_data_ok = 1;
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
